ram_port_arbiter: RTL and testbench

- Parametrised byte-serial RAM controller serving NUM_PORTS requesters (I-fetch, LSB, future DMA) over one 8-bit RAM port.
- Arbitrates among ports, latches the winning request, then issues 1/2/4/8 little-endian byte accesses.
- Tolerates a configurable RAM read latency and returns sign- or zero-extended load data with a one-cycle done pulse.

---
 rtl/ram_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: arbitrates NUM_PORTS requesters onto one byte-serial RAM port,
// issuing little-endian multi-byte accesses and returning extended load data.
module ram_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int ARB_MODE  = 0
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    input  logic [NUM_PORTS-1:0]        req_en_in,
    input  logic [NUM_PORTS-1:0]        req_wr_in,
    input  logic [NUM_PORTS-1:0]        req_sgn_in,
    input  logic [2*NUM_PORTS-1:0]      req_size_in,
    input  logic [ADDR_W*NUM_PORTS-1:0] req_addr_in,
    input  logic [DATA_W*NUM_PORTS-1:0] req_wdata_in,
    output logic [NUM_PORTS-1:0]        done_out,
    output logic [DATA_W-1:0]           rdata_out,
    output logic                        busy_out,
    input  logic [7:0]                  ram_in,
    output logic                        ram_rw_out,
    output logic [ADDR_W-1:0]           ram_addr_out,
    output logic [7:0]                  ram_data_out
);
    localparam int MAXB = DATA_W / 8;
    localparam int GW   = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          gnt_q, gnt_d, ptr_q, ptr_d, pick;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d, rbuf_q, rbuf_d, rdata_q, rdata_d, ext;
    logic                   wr_q, wr_d, sgn_q, sgn_d, found, cap_en;
    logic [2:0]             last_q, last_d;
    logic [3:0]             cyc_q, cyc_d, lsz;
    logic [NUM_PORTS-1:0]   done_q, done_d, req_m;
    int                     idx, k, nbits;

    // Ports that are completing this cycle sit out one arbitration round.
    always_comb begin
        req_m = req_en_in & ~done_q;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            idx = ARB_MODE != 0 ? (int'(ptr_q) + 1 + p) % NUM_PORTS : p;
            if (!found && req_m[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // cyc_q counts cycles since the grant; byte k lands on ram_in RD_LAT-1 cycles after issue.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        sgn_d   = sgn_q;
        last_d  = last_q;
        cyc_d   = cyc_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        done_d  = '0;
        ext     = '0;
        lsz     = '0;
        k       = int'(cyc_q) + 1 - RD_LAT;
        nbits   = 8 * (int'(last_q) + 1);
        cap_en  = state_q != IDLE && !wr_q && k >= 0;
        if (cap_en) rbuf_d[8*k +: 8] = ram_in;
        for (int b = 0; b < DATA_W; b++)
            ext[b] = b < nbits ? rbuf_d[b] : sgn_q & rbuf_d[nbits-1];
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ISSUE;
                    gnt_d   = pick;
                    ptr_d   = ARB_MODE != 0 ? pick : ptr_q;
                    addr_d  = req_addr_in[ADDR_W*pick +: ADDR_W];
                    wdata_d = req_wdata_in[DATA_W*pick +: DATA_W];
                    wr_d    = req_wr_in[pick];
                    sgn_d   = req_sgn_in[pick];
                    cyc_d   = '0;
                    lsz     = 4'd1 << req_size_in[2*pick +: 2];
                    last_d  = 3'((lsz > 4'(MAXB) ? 4'(MAXB) : lsz) - 4'd1);
                end
            end
            ISSUE: begin
                cyc_d = cyc_q + 4'd1;
                if (cyc_q == {1'b0, last_q}) begin
                    state_d        = wr_q ? IDLE : DRAIN;
                    done_d[gnt_q]  = wr_q;
                end
            end
            default: cyc_d = cyc_q + 4'd1;
        endcase
        if (cap_en && k == int'(last_q)) begin
            state_d       = IDLE;
            done_d[gnt_q] = 1'b1;
            rdata_d       = ext;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= GW'(NUM_PORTS - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            last_q  <= '0;
            cyc_q   <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            sgn_q   <= sgn_d;
            last_q  <= last_d;
            cyc_q   <= cyc_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    assign done_out     = done_q;
    assign rdata_out    = rdata_q;
    assign busy_out     = state_q != IDLE;
    assign ram_rw_out   = state_q == ISSUE && wr_q && rdy_in;
    assign ram_addr_out = state_q == ISSUE ? addr_q + ADDR_W'(cyc_q) : '0;
    assign ram_data_out = state_q == ISSUE && wr_q ? wdata_q[8*cyc_q +: 8] : '0;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed checks on two configurations (32b/RD_LAT1/fixed, 64b/RD_LAT3/RR).
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rdy_a, rst_b, rdy_b;
    logic [1:0]  en_a, wr_a, sgn_a, en_b, wr_b, sgn_b, done_a, done_b;
    logic [3:0]  size_a, size_b;
    logic [63:0] addr_a, wdata_a, addr_b;
    logic [127:0] wdata_b;
    logic [31:0] rdata_a, ram_addr_a, ram_addr_b;
    logic [63:0] rdata_b;
    logic        busy_a, busy_b, ram_rw_a, ram_rw_b;
    logic [7:0]  ram_in_a, ram_in_b, ram_data_a, ram_data_b;

    logic [7:0]  mem_a [0:4095];
    logic [7:0]  mem_b [0:4095];
    logic [11:0] a1_b, a2_b;
    logic [19:0] wlog_a [0:63];
    int          wn_a = 0;
    int          tests = 0, fails = 0, base;
    logic [63:0] v;

    ram_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .RD_LAT(1), .ARB_MODE(0)) dut_a (
        .clk_in(clk), .rst_in(rst_a), .rdy_in(rdy_a), .req_en_in(en_a), .req_wr_in(wr_a),
        .req_sgn_in(sgn_a), .req_size_in(size_a), .req_addr_in(addr_a), .req_wdata_in(wdata_a),
        .done_out(done_a), .rdata_out(rdata_a), .busy_out(busy_a), .ram_in(ram_in_a),
        .ram_rw_out(ram_rw_a), .ram_addr_out(ram_addr_a), .ram_data_out(ram_data_a));

    ram_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(64), .RD_LAT(3), .ARB_MODE(1)) dut_b (
        .clk_in(clk), .rst_in(rst_b), .rdy_in(rdy_b), .req_en_in(en_b), .req_wr_in(wr_b),
        .req_sgn_in(sgn_b), .req_size_in(size_b), .req_addr_in(addr_b), .req_wdata_in(wdata_b),
        .done_out(done_b), .rdata_out(rdata_b), .busy_out(busy_b), .ram_in(ram_in_b),
        .ram_rw_out(ram_rw_b), .ram_addr_out(ram_addr_b), .ram_data_out(ram_data_b));

    // RAM models: A returns data in the address cycle, B two cycles later.
    assign ram_in_a = mem_a[ram_addr_a[11:0]];
    assign ram_in_b = mem_b[a2_b];
    always @(posedge clk) if (rdy_b) begin
        a1_b <= ram_addr_b[11:0];
        a2_b <= a1_b;
    end
    always @(posedge clk) if (rdy_a && ram_rw_a) begin
        wlog_a[wn_a] <= {ram_addr_a[11:0], ram_data_a};
        wn_a <= wn_a + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input int p, input logic w, input logic s, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd);
        wr_a[p] = w; sgn_a[p] = s; size_a[2*p +: 2] = sz;
        addr_a[32*p +: 32] = ad; wdata_a[32*p +: 32] = wd;
    endtask

    task automatic set_b(input int p, input logic w, input logic s, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [63:0] wd);
        wr_b[p] = w; sgn_b[p] = s; size_b[2*p +: 2] = sz;
        addr_b[32*p +: 32] = ad; wdata_b[64*p +: 64] = wd;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        {en_a, wr_a, sgn_a, size_a, addr_a, wdata_a} = '0;
        {en_b, wr_b, sgn_b, size_b, addr_b, wdata_b} = '0;
        rst_a = 1'b1; rst_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
        tick;
        chk("rst_done_a", done_a, 0);
        chk("rst_rdata_a", rdata_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_rw_a", ram_rw_a, 0);
        chk("rst_addr_a", ram_addr_a, 0);
        chk("rst_data_a", ram_data_a, 0);
        chk("rst_done_b", done_b, 0);
        chk("rst_rdata_b", rdata_b, 0);
        chk("rst_busy_b", busy_b, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick;

        // single word write from port 1
        set_a(1, 1'b1, 1'b0, 2'd2, 32'h100, 32'hDEADBEEF);
        en_a = 2'b10; base = wn_a;
        tick;
        en_a = 2'b00;
        v = 64'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            chk("wr_rw", ram_rw_a, 1);
            chk("wr_addr", ram_addr_a, 32'h100 + i);
            chk("wr_data", ram_data_a, v[8*i +: 8]);
            chk("wr_nodone", done_a, 0);
            tick;
        end
        chk("wr_done", done_a, 2'b10);
        chk("wr_idle", busy_a, 0);
        chk("wr_rw_off", ram_rw_a, 0);
        tick;
        chk("wr_done_pulse", done_a, 0);
        chk("wr_count", wn_a - base, 4);
        for (int i = 0; i < 4; i++) chk("wr_log", wlog_a[base+i], {12'h100 + 12'(i), v[8*i +: 8]});

        // signed and unsigned byte loads
        mem_a[12'h20] = 8'h80;
        set_a(0, 1'b0, 1'b1, 2'd0, 32'h20, 32'h0);
        en_a = 2'b01;
        tick;
        en_a = 2'b00;
        chk("lb_rw", ram_rw_a, 0);
        chk("lb_addr", ram_addr_a, 32'h20);
        tick;
        chk("lb_done", done_a, 2'b01);
        chk("lb_sext", rdata_a, 32'hFFFFFF80);
        tick;
        chk("lb_done_pulse", done_a, 0);
        set_a(0, 1'b0, 1'b0, 2'd0, 32'h20, 32'h0);
        en_a = 2'b01;
        tick;
        en_a = 2'b00;
        tick;
        chk("lbu_done", done_a, 2'b01);
        chk("lbu_zext", rdata_a, 32'h00000080);
        tick;

        // fixed priority: port 0 first, port 1 after port 0 drops
        set_a(0, 1'b1, 1'b0, 2'd0, 32'h200, 32'h11);
        set_a(1, 1'b1, 1'b0, 2'd0, 32'h300, 32'h22);
        en_a = 2'b11;
        tick;
        chk("fp_first_addr", ram_addr_a, 32'h200);
        chk("fp_first_data", ram_data_a, 8'h11);
        en_a = 2'b10;
        tick;
        chk("fp_first_done", done_a, 2'b01);
        tick;
        chk("fp_second_addr", ram_addr_a, 32'h300);
        chk("fp_second_data", ram_data_a, 8'h22);
        en_a = 2'b00;
        tick;
        chk("fp_second_done", done_a, 2'b10);
        chk("fp_rdata_kept", rdata_a, 32'h00000080);
        tick;

        // stall for three cycles during byte 1 of a write
        set_a(0, 1'b1, 1'b0, 2'd2, 32'h400, 32'h44332211);
        en_a = 2'b01; base = wn_a;
        tick;
        en_a = 2'b00;
        chk("st_b0_addr", ram_addr_a, 32'h400);
        chk("st_b0_data", ram_data_a, 8'h11);
        tick;
        chk("st_b1_addr", ram_addr_a, 32'h401);
        rdy_a = 1'b0;
        repeat (3) begin
            #1;
            chk("st_rw_low", ram_rw_a, 0);
            chk("st_addr_hold", ram_addr_a, 32'h401);
            chk("st_nodone", done_a, 0);
            tick;
        end
        rdy_a = 1'b1;
        #1;
        chk("st_resume_rw", ram_rw_a, 1);
        chk("st_resume_data", ram_data_a, 8'h22);
        tick;
        chk("st_b2_data", ram_data_a, 8'h33);
        tick;
        chk("st_b3_data", ram_data_a, 8'h44);
        tick;
        chk("st_done", done_a, 2'b01);
        chk("st_count", wn_a - base, 4);
        v = 64'h44332211;
        for (int i = 0; i < 4; i++) chk("st_log", wlog_a[base+i], {12'h400 + 12'(i), v[8*i +: 8]});
        tick;

        // round-robin alternation with both ports requesting
        set_b(0, 1'b1, 1'b0, 2'd0, 32'h500, 64'h55);
        set_b(1, 1'b1, 1'b0, 2'd0, 32'h600, 64'h66);
        en_b = 2'b11;
        for (int g = 0; g < 4; g++) begin
            tick;
            chk("rr_grant_addr", ram_addr_b, g % 2 ? 32'h600 : 32'h500);
            tick;
            chk("rr_done", done_b, g % 2 ? 2'b10 : 2'b01);
        end
        en_b = 2'b00;
        tick;
        chk("rr_idle", busy_b, 0);

        // halfword load with RD_LAT 3
        mem_b[12'h40] = 8'h34; mem_b[12'h41] = 8'h12;
        set_b(0, 1'b0, 1'b0, 2'd1, 32'h40, 64'h0);
        en_b = 2'b01;
        tick;
        en_b = 2'b00;
        chk("lh_rw0", ram_rw_b, 0);
        chk("lh_addr0", ram_addr_b, 32'h40);
        tick;
        chk("lh_rw1", ram_rw_b, 0);
        chk("lh_addr1", ram_addr_b, 32'h41);
        chk("lh_nodone1", done_b, 0);
        tick;
        chk("lh_drain_rw", ram_rw_b, 0);
        chk("lh_drain_addr", ram_addr_b, 0);
        chk("lh_drain_busy", busy_b, 1);
        tick;
        chk("lh_nodone3", done_b, 0);
        tick;
        chk("lh_done", done_b, 2'b01);
        chk("lh_data", rdata_b, 64'h1234);
        tick;

        // async reset in the middle of a doubleword read
        v = 64'hF0E1D2C3B4A59687;
        for (int i = 0; i < 8; i++) mem_b[12'h80 + 12'(i)] = v[8*i +: 8];
        set_b(0, 1'b0, 1'b1, 2'd3, 32'h80, 64'h0);
        en_b = 2'b01;
        tick;
        en_b = 2'b00;
        tick;
        #2 rst_b = 1'b1;
        #1;
        chk("ar_busy", busy_b, 0);
        chk("ar_rw", ram_rw_b, 0);
        chk("ar_addr", ram_addr_b, 0);
        chk("ar_done", done_b, 0);
        chk("ar_rdata", rdata_b, 0);
        tick;
        tick;
        rst_b = 1'b0;
        repeat (3) begin
            tick;
            chk("ar_no_done", done_b, 0);
            chk("ar_stay_idle", busy_b, 0);
        end

        // doubleword load after reset
        en_b = 2'b01;
        tick;
        en_b = 2'b00;
        for (int i = 1; i < 10; i++) begin
            tick;
            chk("ld_nodone", done_b, 0);
        end
        tick;
        chk("ld_done", done_b, 2'b01);
        chk("ld_data", rdata_b, 64'hF0E1D2C3B4A59687);
        tick;
        chk("ld_done_pulse", done_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
